frame_capture_rx: RTL

Receive-side counterpart of the rasterizer's pixel output stream. Consumes the `{frame_start, pixel_data[3:0]}` beats driven by the graphics processor and reassembles them into an 8x8 monochrome frame buffer. Exposes a registered row-read port, a frame-complete pulse and framing-error reporting. Used in the on-chip loopback/self-test path and as the reference consumer for the display side of the interface.

---
 rtl/frame_capture_pkg.sv | 29 ++
 rtl/frame_store.sv | 56 +++++
 rtl/frame_capture_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/frame_capture_pkg.sv
// Shared constants, FSM state type and beat-to-buffer mapping for frame_capture_rx.
package frame_capture_pkg;

    localparam int ROWS          = 8;
    localparam int NIB_PER_FRAME = 16;
    localparam int NIB_W         = 4;
    localparam int ROW_W         = $clog2(ROWS);
    localparam int BEAT_W        = $clog2(NIB_PER_FRAME);
    localparam int ROW_BITS      = 2 * NIB_W;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic             hi;
    } nib_loc_t;

    // Beat k lands in row k>>1; odd beats fill the upper nibble of that row.
    function automatic nib_loc_t nib_loc(input logic [BEAT_W-1:0] k);
        nib_loc_t l;
        l.row = k[BEAT_W-1:1];
        l.hi  = k[0];
        return l;
    endfunction

endpackage

// File: rtl/frame_store.sv
// 8x8 pixel store: nibble write port, registered row read port, async clear.
// With FRAME_CAPTURE_DOUBLE_BUF_EN the read port sees a front copy updated only on commit.
module frame_store
    import frame_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  nib_loc_t            wr_loc_i,
    input  logic [NIB_W-1:0]    wr_nib_i,
    input  logic                commit_i,
    input  logic [ROW_W-1:0]    rd_row_i,
    output logic [ROW_BITS-1:0] rd_data_o
);

    logic [ROWS-1:0][ROW_BITS-1:0] back_q, back_d;
    logic [ROWS-1:0][ROW_BITS-1:0] vis;
    logic [ROW_BITS-1:0]           rd_data_q;

    always_comb begin
        back_d = back_q;
        if (wr_en_i) begin
            if (wr_loc_i.hi) back_d[wr_loc_i.row][ROW_BITS-1:NIB_W] = wr_nib_i;
            else             back_d[wr_loc_i.row][NIB_W-1:0]        = wr_nib_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) back_q <= '0;
        else        back_q <= back_d;
    end

`ifdef FRAME_CAPTURE_DOUBLE_BUF_EN
    logic [ROWS-1:0][ROW_BITS-1:0] front_q;

    // Commit takes back_d so the final beat of the frame is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        front_q <= '0;
        else if (commit_i) front_q <= back_d;
    end

    assign vis = front_q;
`else
    logic unused_commit;
    assign unused_commit = commit_i;
    assign vis = back_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= vis[rd_row_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_capture_rx.sv
// Reassembles 4-bit pixel beats into an 8x8 frame; reports commit/abort and frame count.
// Define FRAME_CAPTURE_DOUBLE_BUF_EN to hide partial frames behind a front buffer.
module frame_capture_rx
    import frame_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid,
    input  logic                frame_start,
    input  logic [NIB_W-1:0]    pixel_data,
    input  logic [ROW_W-1:0]    rd_row,
    output logic [ROW_BITS-1:0] rd_data,
    output logic                frame_done,
    output logic                frame_err,
    output logic                busy,
    output logic [7:0]          frame_cnt
);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              wr_en, commit;
    logic [BEAT_W-1:0] wr_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        wr_idx  = cnt_q;
        case (state_q)
            IDLE: begin
                if (pix_valid && frame_start) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    cnt_d   = BEAT_W'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (pix_valid && frame_start) begin
                    // Restart: this beat becomes nibble 0 of the replacement frame.
                    err_d  = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    cnt_d  = BEAT_W'(1);
                end else if (pix_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == BEAT_W'(NIB_PER_FRAME - 1)) begin
                        commit  = 1'b1;
                        done_d  = 1'b1;
                        fcnt_d  = fcnt_q + 8'd1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    frame_store u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_loc_i  (nib_loc(wr_idx)),
        .wr_nib_i  (pixel_data),
        .commit_i  (commit),
        .rd_row_i  (rd_row),
        .rd_data_o (rd_data)
    );

    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == CAPTURE);
    assign frame_cnt  = fcnt_q;

endmodule
